// File: rtl/max2_log_pkg.sv
// Shared constants for the second-largest change logger: event layout and drop counter limits.
package max2_log_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;
    localparam int EV_W      = DEF_WIDTH + DEF_CNT_W;

    localparam int            DROP_W   = 8;
    localparam logic [7:0]    DROP_MAX = 8'hFF;

    // Event word layout: {value, index}, index in the low bits.
    localparam int EV_IDX_LSB = 0;

    function automatic int ev_val_lsb(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/max2_change_logger_fifo.sv
// First-word-fall-through event FIFO; head reads 0 while empty.
module sync_fifo_fwft #(
    parameter int DW    = max2_log_pkg::EV_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DW-1:0]            head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/max2_change_logger.sv
// Logs each change of the tracker's second-largest output as {value, sample index}
// into a small FWFT FIFO drained over valid/ready; overflowed events are counted.
module max2_change_logger
    import max2_log_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         value,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [WIDTH-1:0]         ev_value,
    output logic [CNT_W-1:0]         ev_index,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int EVW     = WIDTH + CNT_W;
    localparam int VAL_LSB = ev_val_lsb(CNT_W);

    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] idx;
    logic             change;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    logic [EVW-1:0]   ev_din;
    logic [EVW-1:0]   head;

    // clr masks the sample entirely: no event, no index advance.
    assign change   = in_valid && !clr && (value != prev);
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign push     = change && (!full || pop);
    assign drop     = change && full && !pop;
    assign ev_din   = {value, idx};
    assign ev_value = head[VAL_LSB +: WIDTH];
    assign ev_index = head[EV_IDX_LSB +: CNT_W];

    sync_fifo_fwft #(
        .DW    (EVW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (ev_din),
        .full  (full),
        .empty (empty),
        .level (level),
        .head  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            idx      <= '0;
            drop_cnt <= '0;
        end else if (clr) begin
            prev     <= '0;
            idx      <= '0;
            drop_cnt <= '0;
        end else begin
            if (in_valid) begin
                prev <= value;
                idx  <= idx + CNT_W'(1);
            end
            if (drop && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule
